// File: rtl/kernel_bank.sv
// kernel_bank: runtime-programmable KSIZE x KSIZE kernel store with frame-aligned selection and slot commit.
// A serially loaded staging buffer is committed to its target slot only on a frame boundary.
module kernel_bank #(
    parameter int KSIZE     = 5,
    parameter int DW_K      = 8,
    parameter int DW_DIV    = 4,
    parameter int NUM_SLOTS = 4,
    localparam int SELW     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [SELW-1:0]             sel_in,
    input  logic                        frame_start,
    input  logic                        ld_start,
    input  logic [SELW-1:0]             ld_slot,
    input  logic [DW_DIV-1:0]           ld_div,
    input  logic                        ld_valid,
    input  logic [DW_K-1:0]             ld_data,
    output logic                        ld_ready,
    output logic                        ld_pending,
    output logic                        ld_done,
    output logic [KSIZE*KSIZE*DW_K-1:0] kernel,
    output logic [DW_DIV-1:0]           div,
    output logic [SELW-1:0]             sel_active
);
    localparam int NT  = KSIZE * KSIZE;
    localparam int IW  = (NT > 1) ? $clog2(NT) : 1;
    localparam int CTR = NT / 2;

    // Ascending tap range puts tap 0 in the MSBs of the flattened kernel bus.
    typedef logic [0:NT-1][DW_K-1:0] kern_t;
    typedef enum logic [1:0] {IDLE, LOAD, WAIT_FRAME} state_t;

    function automatic logic [DW_K-1:0] preset_tap(input int s, input int t);
        int dr, dc, v;
        dr = t / KSIZE - KSIZE / 2;
        dc = t % KSIZE - KSIZE / 2;
        if (KSIZE == 5 && s == 1)
            v = (dr >= -1 && dr <= 1 && dc >= -1 && dc <= 1) ?
                dc * (2 - (dr < 0 ? -dr : dr)) + dr * (2 - (dc < 0 ? -dc : dc)) : 0;
        else if (KSIZE == 5 && s == 2)
            v = (t == CTR) ? 4 : 1;
        else if (KSIZE == 5 && s == 3)
            v = (t == CTR) ? 31 : -1;
        else
            v = (t == CTR) ? 1 : 0;
        return DW_K'(v);
    endfunction

    function automatic kern_t preset_k(input int s);
        kern_t k;
        for (int t = 0; t < NT; t++)
            k[t] = preset_tap(s, t);
        return k;
    endfunction

    function automatic logic [DW_DIV-1:0] preset_div(input int s);
        return (KSIZE != 5) ? '0 :
               (s == 1) ? DW_DIV'(2) : (s == 2) ? DW_DIV'(5) : (s == 3) ? DW_DIV'(4) : '0;
    endfunction

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q;
    logic [SELW-1:0]     tgt_q, sel_q;
    logic [DW_DIV-1:0]   tdiv_q, div_q;
    kern_t               stage_q, kernel_q;
    logic                done_q;
    kern_t               slot_k_q   [NUM_SLOTS];
    logic [DW_DIV-1:0]   slot_div_q [NUM_SLOTS];

    logic start_ok, beat, last, commit, sel_ok, bypass;

    assign start_ok = state_q == IDLE && ld_start && int'(ld_slot) < NUM_SLOTS;
    assign beat     = state_q == LOAD && ld_valid;
    assign last     = beat && idx_q == IW'(NT - 1);
    assign commit   = state_q == WAIT_FRAME && frame_start;
    assign sel_ok   = frame_start && int'(sel_in) < NUM_SLOTS;
    assign bypass   = commit && sel_in == tgt_q;

    always_comb begin
        state_d = state_q;
        if (start_ok)
            state_d = LOAD;
        else if (last)
            state_d = WAIT_FRAME;
        else if (commit)
            state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            tgt_q    <= '0;
            tdiv_q   <= '0;
            stage_q  <= '0;
            kernel_q <= preset_k(0);
            div_q    <= preset_div(0);
            sel_q    <= '0;
            done_q   <= 1'b0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                slot_k_q[s]   <= preset_k(s);
                slot_div_q[s] <= preset_div(s);
            end
        end else begin
            state_q <= state_d;
            done_q  <= commit;
            if (start_ok) begin
                idx_q  <= '0;
                tgt_q  <= ld_slot;
                tdiv_q <= ld_div;
            end
            if (beat) begin
                stage_q[idx_q] <= ld_data;
                idx_q          <= idx_q + 1'b1;
            end
            if (commit) begin
                slot_k_q[tgt_q]   <= stage_q;
                slot_div_q[tgt_q] <= tdiv_q;
            end
            // A slot committed this cycle is not yet in the array, so forward staging.
            if (sel_ok) begin
                sel_q    <= sel_in;
                kernel_q <= bypass ? stage_q : slot_k_q[sel_in];
                div_q    <= bypass ? tdiv_q : slot_div_q[sel_in];
            end
        end
    end

    assign ld_ready   = state_q == LOAD;
    assign ld_pending = state_q == WAIT_FRAME;
    assign ld_done    = done_q;
    assign kernel     = kernel_q;
    assign div        = div_q;
    assign sel_active = sel_q;
endmodule

// File: tb/tb_kernel_bank.sv
// tb_kernel_bank: directed stimulus for kernel_bank (6 slots) with a cycle-by-cycle reference model
// plus literal expectations for the preset and loaded kernels.
module tb_kernel_bank;
    localparam logic [199:0] ID    = 200'd1 << 96;
    localparam logic [199:0] BLUR  = {{12{8'h01}}, 8'h04, {12{8'h01}}};
    localparam logic [199:0] SHARP = {{12{8'hFF}}, 8'h1F, {12{8'hFF}}};
    localparam logic [199:0] SOBEL = {40'h0, 40'h00FEFE0000, 40'h00FE000200, 40'h0000020200, 40'h0};
    localparam logic [199:0] ALL3  = {25{8'h03}};

    logic         clk = 1'b0, rst = 1'b1;
    logic [2:0]   sel_in = '0, ld_slot = '0;
    logic         frame_start = 1'b0, ld_start = 1'b0, ld_valid = 1'b0;
    logic [3:0]   ld_div = '0;
    logic [7:0]   ld_data = '0;
    logic         ld_ready, ld_pending, ld_done;
    logic [199:0] kernel;
    logic [3:0]   div;
    logic [2:0]   sel_active;

    int n_checks = 0, n_fail = 0;

    kernel_bank #(.NUM_SLOTS(6)) dut (
        .clk(clk), .rst(rst), .sel_in(sel_in), .frame_start(frame_start),
        .ld_start(ld_start), .ld_slot(ld_slot), .ld_div(ld_div),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .ld_pending(ld_pending), .ld_done(ld_done), .kernel(kernel),
        .div(div), .sel_active(sel_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: slot contents, active selection and load progress as plain variables.
    logic [199:0] m_slot [6];
    logic [3:0]   m_sdiv [6];
    logic [199:0] m_k, m_stage;
    logic [3:0]   m_div, m_tdiv;
    logic [2:0]   m_sel, m_tgt;
    bit           m_load, m_pend, m_done, m_live = 0;
    int           m_cnt;

    always @(posedge clk) begin
        bit idle, commit;
        if (rst) begin
            m_slot = '{ID, SOBEL, BLUR, SHARP, ID, ID};
            m_sdiv = '{4'd0, 4'd2, 4'd5, 4'd4, 4'd0, 4'd0};
            m_k = ID; m_div = 0; m_sel = 0; m_stage = '0;
            m_load = 0; m_pend = 0; m_done = 0; m_cnt = 0;
        end else begin
            idle   = !m_load && !m_pend;
            commit = m_pend && frame_start;
            m_done = commit;
            if (commit) begin
                m_slot[m_tgt] = m_stage;
                m_sdiv[m_tgt] = m_tdiv;
                m_pend = 0;
            end
            if (frame_start && sel_in < 6) begin
                m_sel = sel_in; m_k = m_slot[sel_in]; m_div = m_sdiv[sel_in];
            end
            if (m_load && ld_valid) begin
                m_stage[199 - 8 * m_cnt -: 8] = ld_data;
                m_cnt++;
                if (m_cnt == 25) begin m_load = 0; m_pend = 1; end
            end else if (idle && ld_start && ld_slot < 6) begin
                m_load = 1; m_cnt = 0; m_tgt = ld_slot; m_tdiv = ld_div;
            end
        end
        m_live = 1;
    end

    always @(negedge clk) if (m_live) begin
        chk("model kernel", kernel, m_k);
        chk("model div", {196'd0, div}, {196'd0, m_div});
        chk("model sel_active", {197'd0, sel_active}, {197'd0, m_sel});
        chk("model ld_ready", {199'd0, ld_ready}, {199'd0, m_load});
        chk("model ld_pending", {199'd0, ld_pending}, {199'd0, m_pend});
        chk("model ld_done", {199'd0, ld_done}, {199'd0, m_done});
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [2:0] s);
        sel_in = s; frame_start = 1;
        cyc(1);
        frame_start = 0;
    endtask

    // kind 0: constant 0x03, kind 1: tap index, kind 2: index+16 with a stray ld_start mid-load
    task automatic load(input logic [2:0] s, input logic [3:0] d, input int n, input int kind,
                        input bit fs_last, input bit gaps);
        ld_start = 1; ld_slot = s; ld_div = d;
        cyc(1);
        ld_start = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                ld_valid = 0;
                cyc(1);
            end
            ld_valid = 1;
            ld_data  = (kind == 0) ? 8'h03 : (kind == 1) ? 8'(i) : 8'(i + 16);
            if (fs_last && i == 24) frame_start = 1;
            if (kind == 2 && i == 3) begin ld_start = 1; ld_slot = 1; ld_div = 4'hF; end
            cyc(1);
            ld_valid = 0; frame_start = 0; ld_start = 0;
        end
    endtask

    initial begin
        logic [199:0] ramp, r16;
        for (int i = 0; i < 25; i++) begin
            ramp[199 - 8 * i -: 8] = 8'(i);
            r16[199 - 8 * i -: 8]  = 8'(i + 16);
        end
        cyc(3);
        rst = 0;
        chk("reset kernel", kernel, ID);
        chk("reset div", {196'd0, div}, 200'd0);
        chk("reset sel", {197'd0, sel_active}, 200'd0);
        chk("reset ready", {199'd0, ld_ready}, 200'd0);

        pulse(3'd2);
        chk("sel2 kernel", kernel, BLUR);
        chk("sel2 div", {196'd0, div}, 200'd5);
        chk("sel2 sel", {197'd0, sel_active}, 200'd2);
        sel_in = 3'd3;
        cyc(3);
        chk("no pulse kernel", kernel, BLUR);
        chk("no pulse sel", {197'd0, sel_active}, 200'd2);

        load(3'd0, 4'd3, 25, 0, 0, 1);
        chk("loaded ready", {199'd0, ld_ready}, 200'd0);
        chk("loaded pending", {199'd0, ld_pending}, 200'd1);
        chk("loaded kernel untouched", kernel, BLUR);
        cyc(2);
        pulse(3'd0);
        chk("commit kernel", kernel, ALL3);
        chk("commit div", {196'd0, div}, 200'd3);
        chk("commit done", {199'd0, ld_done}, 200'd1);
        cyc(1);
        chk("done falls", {199'd0, ld_done}, 200'd0);
        chk("pending clear", {199'd0, ld_pending}, 200'd0);

        sel_in = 3'd4;
        load(3'd4, 4'd1, 25, 1, 1, 0);
        chk("coincide pending", {199'd0, ld_pending}, 200'd1);
        chk("coincide done", {199'd0, ld_done}, 200'd0);
        chk("coincide kernel", kernel, ID);
        cyc(1);
        pulse(3'd4);
        chk("late commit kernel", kernel, ramp);
        chk("late commit div", {196'd0, div}, 200'd1);
        chk("late commit done", {199'd0, ld_done}, 200'd1);

        ld_start = 1; ld_slot = 3'd7; ld_div = 4'd9;
        cyc(1);
        ld_start = 0;
        cyc(2);
        chk("oob slot ready", {199'd0, ld_ready}, 200'd0);
        load(3'd5, 4'd6, 25, 2, 0, 0);
        chk("stray start pending", {199'd0, ld_pending}, 200'd1);
        pulse(3'd5);
        chk("slot5 kernel", kernel, r16);
        chk("slot5 div", {196'd0, div}, 200'd6);
        pulse(3'd7);
        chk("oob sel kept", {197'd0, sel_active}, 200'd5);
        chk("oob sel kernel", kernel, r16);
        pulse(3'd1);
        chk("slot1 untouched", kernel, SOBEL);

        load(3'd2, 4'd0, 10, 0, 0, 0);
        rst = 1;
        cyc(1);
        rst = 0;
        chk("abort ready", {199'd0, ld_ready}, 200'd0);
        chk("abort pending", {199'd0, ld_pending}, 200'd0);
        pulse(3'd1);
        chk("sobel kernel", kernel, SOBEL);
        chk("sobel div", {196'd0, div}, 200'd2);
        pulse(3'd0);
        chk("slot0 restored", kernel, ID);
        pulse(3'd4);
        chk("slot4 restored", kernel, ID);
        pulse(3'd3);
        chk("sharpen kernel", kernel, SHARP);
        chk("sharpen div", {196'd0, div}, 200'd4);
        pulse(3'd2);
        chk("blur after rst", kernel, BLUR);

        cyc(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
